// File: rtl/rt1_pkg.sv
// Shared types and helpers for the return-to-one serialiser.
package rt1_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_HALF = 2'd1,
    RET_HALF  = 2'd2
  } state_t;

  localparam int HALF_CYC_MIN = 2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rt1_half_timer.sv
// Half-bit cycle counter; exposes its terminal count now and look-ahead flags
// for the next cycle so the encoder can register its outputs without added latency.
module rt1_half_timer
  import rt1_pkg::*;
#(
  parameter int HALF_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic half_end,
  output logic half_end_nx,
  output logic mid_nx
);

  localparam int HC = (HALF_CYC < HALF_CYC_MIN) ? HALF_CYC_MIN : HALF_CYC;
  localparam int CW = cnt_w(HC);
  localparam logic [CW-1:0] LAST = CW'(HC - 1);
  localparam logic [CW-1:0] MID  = CW'(HC / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  always_comb begin
    cnt_nx = (clr || half_end) ? '0 : cnt + CW'(1);
  end

  assign half_end    = (cnt == LAST);
  assign half_end_nx = (cnt_nx == LAST);
  assign mid_nx      = (cnt_nx == MID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nx;
  end

endmodule

// File: rtl/rt1_serial_encoder.sv
// RT1 serialiser: MSB-first, each bit = data level for one half-bit then forced 1.
// All line-side outputs are flops fed from next-state values.
module rt1_serial_encoder
  import rt1_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HALF_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              clkout,
  output logic              sample_stb,
  output logic              busy,
  output logic              done
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [BW-1:0]     bit_cnt, bit_nx;
  logic              half_end, half_end_nx, mid_nx;
  logic              last_cycle, xfer;
  logic              sout_nx, clkout_nx, stb_nx, busy_nx, done_nx;

  rt1_half_timer #(
    .HALF_CYC (HALF_CYC)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (state == IDLE),
    .half_end    (half_end),
    .half_end_nx (half_end_nx),
    .mid_nx      (mid_nx)
  );

  assign last_cycle = (state == RET_HALF) && half_end && (bit_cnt == BIT_LAST);
  assign din_ready  = rst_n && ((state == IDLE) || last_cycle);
  assign xfer       = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      sout       <= 1'b1;
      clkout     <= 1'b1;
      sample_stb <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      bit_cnt    <= bit_nx;
      sout       <= sout_nx;
      clkout     <= clkout_nx;
      sample_stb <= stb_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    bit_nx   = bit_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nx = DATA_HALF;
          shreg_nx = din;
          bit_nx   = '0;
        end
      end
      DATA_HALF: begin
        if (half_end) state_nx = RET_HALF;
      end
      RET_HALF: begin
        if (half_end) begin
          if (bit_cnt == BIT_LAST) begin
            bit_nx = '0;
            if (xfer) begin
              // back-to-back word: no idle gap between frames
              state_nx = DATA_HALF;
              shreg_nx = din;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            state_nx = DATA_HALF;
            shreg_nx = {shreg[DATA_W-2:0], 1'b0};
            bit_nx   = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        bit_nx   = '0;
      end
    endcase
  end

  always_comb begin
    sout_nx   = (state_nx == DATA_HALF) ? shreg_nx[DATA_W-1] : 1'b1;
    clkout_nx = (state_nx != DATA_HALF);
    stb_nx    = (state_nx == DATA_HALF) && mid_nx;
    busy_nx   = (state_nx != IDLE);
    done_nx   = (state_nx == RET_HALF) && half_end_nx && (bit_nx == BIT_LAST);
  end

endmodule

// File: tb/tb_rt1_serial_encoder.sv
// Directed bench for rt1_serial_encoder: 8-bit/HALF_CYC=4 main instance plus a
// 4-bit/HALF_CYC=2 variant instance.
module tb_rt1_serial_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, sout, clkout, sample_stb, busy, done;

  logic [3:0] din_b = 4'h0;
  logic       din_valid_b = 1'b0;
  logic       din_ready_b, sout_b, clkout_b, sample_stb_b, busy_b, done_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rt1_serial_encoder #(.DATA_W(8), .HALF_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .clkout(clkout), .sample_stb(sample_stb), .busy(busy), .done(done)
  );

  rt1_serial_encoder #(.DATA_W(4), .HALF_CYC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
    .sout(sout_b), .clkout(clkout_b), .sample_stb(sample_stb_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] w;
    int         lows;
    logic [7:0] samp;
  } vec_t;

  vec_t vecs[5];

  // Sends one word from IDLE and watches 70 cycles against the expected waveform.
  task automatic run_frame(input logic [7:0] w, output int lows, output logic [7:0] samp,
                           output int nstb, output int done_at, output int busy_n,
                           output int wave_err);
    int   ph, b;
    logic es, ec, et, ed, eb;
    lows = 0; samp = 8'h00; nstb = 0; done_at = -1; busy_n = 0; wave_err = 0;
    din = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (busy) busy_n++;
      if (busy && !sout) lows++;
      if (sample_stb) begin
        samp = {samp[6:0], sout};
        nstb++;
      end
      if (done) done_at = c;
      if (c <= 64) begin
        ph = (c - 1) % 8;
        b  = 7 - (c - 1) / 8;
        es = (ph < 4) ? w[b] : 1'b1;
        ec = (ph >= 4);
        et = (ph == 2);
        ed = (c == 64);
        eb = 1'b1;
      end else begin
        es = 1'b1; ec = 1'b1; et = 1'b0; ed = 1'b0; eb = 1'b0;
      end
      if (sout !== es || clkout !== ec || sample_stb !== et || done !== ed || busy !== eb)
        wave_err++;
      tick();
    end
  endtask

  initial begin
    int         lows, nstb, done_at, busy_n, wave_err, bad, ndone;
    int         acc, d1, d2, lows1, lows2, rdy_early, busy_err;
    logic [7:0] samp, s1, s2;
    logic [15:0] sv, sbv;
    logic       x;

    vecs[0] = '{8'hA5, 16, 8'b1010_0101};
    vecs[1] = '{8'h00, 32, 8'b0000_0000};
    vecs[2] = '{8'hFF,  0, 8'b1111_1111};
    vecs[3] = '{8'h3C, 16, 8'b0011_1100};
    vecs[4] = '{8'h81, 24, 8'b1000_0001};

    // reset values
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sout", sout, 1);
    chk("rst_clkout", clkout, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_done_stb", {done, sample_stb}, 0);
    rst_n = 1'b1;
    tick();

    // idle with no din_valid
    bad = 0; ndone = 0;
    for (int i = 0; i < 50; i++) begin
      if (sout !== 1'b1 || clkout !== 1'b1 || busy !== 1'b0 || din_ready !== 1'b1 ||
          sample_stb !== 1'b0) bad++;
      if (done !== 1'b0) ndone++;
      tick();
    end
    chk("idle_outputs", bad, 0);
    chk("idle_done", ndone, 0);

    // single frames from the table
    for (int v = 0; v < 5; v++) begin
      chk($sformatf("v%0d_ready", v), din_ready, 1);
      run_frame(vecs[v].w, lows, samp, nstb, done_at, busy_n, wave_err);
      chk($sformatf("v%0d_lows", v), lows, vecs[v].lows);
      chk($sformatf("v%0d_samp", v), samp, vecs[v].samp);
      chk($sformatf("v%0d_nstb", v), nstb, 8);
      chk($sformatf("v%0d_done_at", v), done_at, 64);
      chk($sformatf("v%0d_busy", v), busy_n, 64);
      chk($sformatf("v%0d_wave", v), wave_err, 0);
    end

    // back-to-back 00 then FF, din_valid held
    din = 8'h00; din_valid = 1'b1;
    tick();
    din = 8'hFF;
    acc = -1; d1 = -1; d2 = -1; lows1 = 0; lows2 = 0; busy_err = 0;
    for (int c = 1; c <= 140; c++) begin
      x = din_ready && din_valid;
      if (x) acc = c;
      if (busy !== (c <= 128)) busy_err++;
      if (busy && !sout) begin
        if (c <= 64) lows1++;
        else lows2++;
      end
      if (done) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
      tick();
      if (x) din_valid = 1'b0;
    end
    chk("b2b_accept", acc, 64);
    chk("b2b_done1", d1, 64);
    chk("b2b_done2", d2, 128);
    chk("b2b_busy", busy_err, 0);
    chk("b2b_lows1", lows1, 32);
    chk("b2b_lows2", lows2, 0);

    // stall: next word presented right after acceptance
    din = 8'hA5; din_valid = 1'b1;
    tick();
    din = 8'h5A;
    acc = -1; rdy_early = 0; s1 = 8'h00; s2 = 8'h00;
    for (int c = 1; c <= 140; c++) begin
      x = din_ready && din_valid;
      if (din_ready && c < 64) rdy_early++;
      if (x && acc < 0) acc = c;
      if (sample_stb) begin
        if (c <= 64) s1 = {s1[6:0], sout};
        else s2 = {s2[6:0], sout};
      end
      tick();
      if (x) din_valid = 1'b0;
    end
    chk("stall_ready_early", rdy_early, 0);
    chk("stall_accept", acc, 64);
    chk("stall_frame1", s1, 8'hA5);
    chk("stall_frame2", s2, 8'h5A);

    // reset in the middle of a 3C frame
    din = 8'h3C; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (19) tick();
    chk("mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sout", sout, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_clkout", clkout, 1);
    chk("mid_rst_done_ready", {done, din_ready}, 0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 1'b0) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) ndone++;
    end
    chk("mid_rst_quiet", ndone, 0);
    chk("post_rst_ready", din_ready, 1);
    run_frame(8'hC3, lows, samp, nstb, done_at, busy_n, wave_err);
    chk("post_rst_samp", samp, 8'hC3);
    chk("post_rst_lows", lows, 16);
    chk("post_rst_done_at", done_at, 64);
    chk("post_rst_wave", wave_err, 0);

    // variant instance: DATA_W=4, HALF_CYC=2
    chk("var_ready", din_ready_b, 1);
    din_b = 4'b0110; din_valid_b = 1'b1;
    tick();
    din_valid_b = 1'b0;
    sv = 16'h0; sbv = 16'h0; done_at = -1; busy_n = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 16) begin
        sv  = {sv[14:0], sout_b};
        sbv = {sbv[14:0], sample_stb_b};
      end
      if (busy_b) busy_n++;
      if (done_b) done_at = c;
      tick();
    end
    chk("var_sout", sv, 16'b0011_1111_1111_0011);
    chk("var_stb", sbv, 16'b0100_0100_0100_0100);
    chk("var_done_at", done_at, 16);
    chk("var_busy", busy_n, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/rt1_serial_encoder.md
Name: rt1_serial_encoder

Overview:
Return-to-one (RT1) serialiser that sits directly upstream of the RT1 line stage and feeds it its serial stream and bit clock.
- Accepts parallel words over a valid/ready handshake.
- Shifts each word out MSB-first. Each bit is encoded as: data level for one half-bit, then forced '1' for the second half-bit.
- Drives the companion bit-rate clock (clkout), a mid-data-phase sample strobe and frame status.

Parameters:
- DATA_W, 8: word width in bits (≥2).
- HALF_CYC, 4: clk cycles per half-bit (≥2). Bit period = 2*HALF_CYC cycles; frame = DATA_W*2*HALF_CYC cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W  parallel word to send.
- din_valid  in  1  din holds a word.
- din_ready  out  1  block accepts din this cycle (transfer = din_valid & din_ready).
- sout  out  1  RT1-encoded serial line; idles at 1.
- clkout  out  1  bit clock: 0 during data half, 1 during return half and idle.
- sample_stb  out  1  one-cycle pulse at data-half cycle index HALF_CYC/2 (integer division) of every bit.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Reset (rst_n low, asynchronous): sout=1, clkout=1, sample_stb=0, busy=0, done=0, din_ready=0 (din_ready is gated by rst_n), FSM=IDLE, shift register=0, counters=0.
- FSM states: IDLE, DATA_HALF, RET_HALF.
- half_cnt runs 0..HALF_CYC-1 in each half. bit_cnt runs 0..DATA_W-1.
- IDLE:
  - din_ready=1.
  - On transfer: load shift reg with din; go to DATA_HALF with half_cnt=0, bit_cnt=0.
  - Latency: sout carries din[DATA_W-1] from the cycle after acceptance.
- DATA_HALF:
  - sout = shreg MSB; clkout=0.
  - sample_stb=1 when half_cnt==HALF_CYC/2.
  - On half_cnt==HALF_CYC-1: go to RET_HALF.
- RET_HALF:
  - sout=1; clkout=1.
  - On half_cnt==HALF_CYC-1 with bit_cnt<DATA_W-1: shift left, bit_cnt+1, go to DATA_HALF.
  - On half_cnt==HALF_CYC-1 with bit_cnt==DATA_W-1: last cycle of frame. done=1, din_ready=1.
    - If din_valid: load the new word and go straight to DATA_HALF (back-to-back, no idle gap; busy stays 1).
    - Otherwise: go to IDLE.
- busy=1 in DATA_HALF and RET_HALF.
- din_ready=0 in every other non-IDLE cycle. din/din_valid are ignored then; the upstream source must hold them.
- sout, clkout, sample_stb and done are registered, with no combinational path from din.
- Reset mid-frame: outputs return to their reset values immediately. The partial word is discarded and no done is issued. The next accepted word starts a clean frame.
- din_valid deasserted before a transfer: no effect; the block stays IDLE.

Decomposition:
- Package rt1_pkg: state enum (IDLE, DATA_HALF, RET_HALF); constant HALF_CYC_MIN=2; width helper using $clog2 for half_cnt/bit_cnt.
- One sub-module, rt1_half_timer: parameterised HALF_CYC counter with clear input. Outputs half_end (cnt==HALF_CYC-1) and mid (cnt==HALF_CYC/2).
- The FSM, shift register and outputs stay in rt1_serial_encoder.

Test Plan:
1. Post-reset idle: release rst_n, no din_valid for 50 cycles -> sout=1, clkout=1, busy=0, din_ready=1, done never pulses.
2. Single word, DATA_W=8, HALF_CYC=4, din=8'hA5 -> sout low exactly in the data halves of bits 6,4,3,1 (4 cycles each). Frame is 64 cycles. done pulses on cycle 64 after acceptance. busy falls on the next cycle. 8 sample_stb pulses, each seeing sout = 1,0,1,0,0,1,0,1.
3. Back-to-back 8'h00 then 8'hFF with din_valid held -> second word accepted on the done cycle of the first. 128 contiguous busy cycles. sout low for 8×4 cycles in frame 1, never low in frame 2. Two done pulses 64 cycles apart.
4. Stall: din_valid=1 with new data asserted mid-frame -> din_ready=0 until the frame's last cycle. The word is taken exactly on that cycle and the first frame's data is unaffected.
5. Reset mid-frame: assert rst_n low at cycle 20 of an 8'h3C frame -> same-cycle sout=1, busy=0, clkout=1, no done. After release, 8'hC3 transmits correctly in 64 cycles.
6. Parameter variant HALF_CYC=2, DATA_W=4, din=4'b0110 -> 16-cycle frame. sout pattern 0,1,1,1,1,1,0,1 per half-bit. sample_stb on cycle index 1 of each data half.
